// File: rtl/ne555_pulse_meter_if.sv
// rtl/ne555_pulse_meter_if.sv - control, waveform input and readout bundle for ne555_pulse_meter
interface ne555_pulse_meter_if;
  logic       en;
  logic       clear;
  logic       sig_in;
  logic [2:0] rd_sel;
  logic [7:0] rd_data;
  logic       valid;
  logic       ovf;

  modport master (
    output en, clear, sig_in, rd_sel,
    input  rd_data, valid, ovf
  );

  modport slave (
    input  en, clear, sig_in, rd_sel,
    output rd_data, valid, ovf
  );
endinterface

// File: rtl/ne555_pulse_meter.sv
// rtl/ne555_pulse_meter.sv - high/low/period meter for the NE555EX OUT waveform; optional PM_GLITCH_FILTER_EN
module ne555_pulse_meter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ne555_pulse_meter_if.slave   bus
);

  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2,
    ST_BAD    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Input path
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;
  logic                   lvl;
  logic                   lvl_status;
  logic                   s_d_q, s_d_d;
  logic                   rise, fall;

  // Measurement state
  state_t           state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] high_len_q, high_len_d;
  logic [CNT_W-1:0] low_len_q, low_len_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [7:0]       pulse_cnt_q, pulse_cnt_d;
  logic             got_high_q, got_high_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;

  // Counter helpers
  logic             run_sat;
  logic [CNT_W-1:0] run_inc;
  logic [CNT_W:0]   per_sum;
  logic             per_sat;
  logic [CNT_W-1:0] per_val;

  // Readout helpers
  logic [15:0] high_len_16, low_len_16, period_16;
  logic [7:0]  status;

  // Synchroniser shift: sig_in enters at bit 0, s is the oldest stage
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.sig_in};
    s      = sync_q[SYNC_STAGES-1];
  end

`ifdef PM_GLITCH_FILTER_EN
  logic       f_q, f_d;
  logic [1:0] stab_q, stab_d;

  // Filtered level follows s only once s has held a new value for three cycles
  always_comb begin
    f_d    = f_q;
    stab_d = 2'd0;
    if (s != f_q) begin
      if (stab_q == 2'd2) begin
        f_d = s;
      end else begin
        stab_d = stab_q + 2'd1;
      end
    end
    lvl        = f_d;
    lvl_status = f_q;
  end

  // Filter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q    <= 1'b0;
      stab_q <= 2'd0;
    end else begin
      f_q    <= f_d;
      stab_q <= stab_d;
    end
  end
`else
  // No filter: the edge logic sees the synchronised level directly
  always_comb begin
    lvl        = s;
    lvl_status = s;
  end
`endif

  // Edge detection against the delayed level
  always_comb begin
    s_d_d = lvl;
    rise  = lvl & ~s_d_q;
    fall  = ~lvl & s_d_q;
  end

  // Saturating run counter increment and saturating period sum
  always_comb begin
    run_sat = (run_cnt_q == CNT_MAX);
    run_inc = run_sat ? run_cnt_q : run_cnt_q + CNT_ONE;
    per_sum = {1'b0, high_len_q} + {1'b0, run_cnt_q};
    per_sat = per_sum[CNT_W];
    per_val = per_sat ? CNT_MAX : per_sum[CNT_W-1:0];
  end

  // Next-state logic: clear beats en low, en low beats edge handling
  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    high_len_d  = high_len_q;
    low_len_d   = low_len_q;
    period_d    = period_q;
    pulse_cnt_d = pulse_cnt_q;
    got_high_d  = got_high_q;
    valid_d     = valid_q;
    ovf_d       = ovf_q;

    if (bus.clear) begin
      state_d     = WAIT_EDGE;
      run_cnt_d   = '0;
      high_len_d  = '0;
      low_len_d   = '0;
      period_d    = '0;
      pulse_cnt_d = '0;
      got_high_d  = 1'b0;
      valid_d     = 1'b0;
      ovf_d       = 1'b0;
    end else if (!bus.en) begin
      state_d    = WAIT_EDGE;
      run_cnt_d  = '0;
      got_high_d = 1'b0;
    end else begin
      case (state_q)
        WAIT_EDGE: begin
          // The level in progress when we arrive here is partial; skip it
          run_cnt_d = '0;
          if (rise) begin
            state_d   = MEAS_HIGH;
            run_cnt_d = CNT_ONE;
          end else if (fall) begin
            state_d   = MEAS_LOW;
            run_cnt_d = CNT_ONE;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_len_d = run_cnt_q;
            got_high_d = 1'b1;
            run_cnt_d  = CNT_ONE;
            state_d    = MEAS_LOW;
          end else begin
            run_cnt_d = run_inc;
            if (run_sat) ovf_d = 1'b1;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            low_len_d = run_cnt_q;
            run_cnt_d = CNT_ONE;
            state_d   = MEAS_HIGH;
            // A period is only complete if the preceding high was measured
            if (got_high_q) begin
              period_d    = per_val;
              pulse_cnt_d = pulse_cnt_q + 8'd1;
              valid_d     = 1'b1;
              if (per_sat) ovf_d = 1'b1;
            end
          end else begin
            run_cnt_d = run_inc;
            if (run_sat) ovf_d = 1'b1;
          end
        end
        default: begin
          state_d   = WAIT_EDGE;
          run_cnt_d = '0;
        end
      endcase
    end
  end

  // All state registers, asynchronously reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      s_d_q       <= 1'b0;
      state_q     <= WAIT_EDGE;
      run_cnt_q   <= '0;
      high_len_q  <= '0;
      low_len_q   <= '0;
      period_q    <= '0;
      pulse_cnt_q <= '0;
      got_high_q  <= 1'b0;
      valid_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      s_d_q       <= s_d_d;
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      high_len_q  <= high_len_d;
      low_len_q   <= low_len_d;
      period_q    <= period_d;
      pulse_cnt_q <= pulse_cnt_d;
      got_high_q  <= got_high_d;
      valid_q     <= valid_d;
      ovf_q       <= ovf_d;
    end
  end

  // Byte-select readout, zero-extended results; run_cnt is never visible
  always_comb begin
    high_len_16 = '0;
    low_len_16  = '0;
    period_16   = '0;
    high_len_16[CNT_W-1:0] = high_len_q;
    low_len_16[CNT_W-1:0]  = low_len_q;
    period_16[CNT_W-1:0]   = period_q;
    status = {valid_q, ovf_q, state_q, lvl_status, got_high_q, 2'b00};
    case (bus.rd_sel)
      3'd0:    bus.rd_data = high_len_16[7:0];
      3'd1:    bus.rd_data = high_len_16[15:8];
      3'd2:    bus.rd_data = low_len_16[7:0];
      3'd3:    bus.rd_data = low_len_16[15:8];
      3'd4:    bus.rd_data = period_16[7:0];
      3'd5:    bus.rd_data = period_16[15:8];
      3'd6:    bus.rd_data = pulse_cnt_q;
      default: bus.rd_data = status;
    endcase
    bus.valid = valid_q;
    bus.ovf   = ovf_q;
  end

endmodule

// File: tb/tb_ne555_pulse_meter.sv
// tb/tb_ne555_pulse_meter.sv - scoreboard bench for ne555_pulse_meter (CNT_W=16 and CNT_W=9 instances)
module tb_ne555_pulse_meter;

`ifdef PM_GLITCH_FILTER_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 3;
`endif

  logic clk;
  logic rst_n;
  logic rd_req;
  int   n_run;
  int   n_fail;

  ne555_pulse_meter_if ifa ();
  ne555_pulse_meter_if ifb ();

  ne555_pulse_meter #(.CNT_W(16), .SYNC_STAGES(2)) u_dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.slave)
  );

  ne555_pulse_meter #(.CNT_W(9), .SYNC_STAGES(2)) u_dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    int         dut;
    int         kind;
    logic [7:0] exp;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [7:0] mon_act;

  // Monitor: whenever a read is presented, pop the oldest expectation and compare
  always @(negedge clk) begin
    if (rd_req) begin
      n_run = n_run + 1;
      if (sb_q.size() == 0) begin
        n_fail = n_fail + 1;
        $display("FAIL sb_empty: read presented with no expectation queued");
      end else begin
        mon_e = sb_q.pop_front();
        case (mon_e.kind)
          0:       mon_act = (mon_e.dut == 0) ? ifa.rd_data : ifb.rd_data;
          1:       mon_act = {7'd0, (mon_e.dut == 0) ? ifa.valid : ifb.valid};
          default: mon_act = {7'd0, (mon_e.dut == 0) ? ifa.ovf : ifb.ovf};
        endcase
        if (mon_act !== mon_e.exp) begin
          n_fail = n_fail + 1;
          $display("FAIL %s: got 0x%02h, expected 0x%02h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sig(input logic v);
    ifa.sig_in = v;
    ifb.sig_in = v;
  endtask

  task automatic level(input logic v, input int n);
    set_sig(v);
    tick(n);
  endtask

  // kind 0 = rd_data at sel, 1 = valid port, 2 = ovf port
  task automatic rd(input int dut, input int kind, input logic [2:0] sel,
                    input logic [7:0] exp, input string name);
    exp_t e;
    if (dut == 0) ifa.rd_sel = sel;
    else          ifb.rd_sel = sel;
    e.name = name;
    e.dut  = dut;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
    rd_req = 1'b1;
    tick(1);
    rd_req = 1'b0;
  endtask

  initial begin
    n_run      = 0;
    n_fail     = 0;
    rd_req     = 1'b0;
    rst_n      = 1'b0;
    ifa.en     = 1'b0;
    ifa.clear  = 1'b0;
    ifa.rd_sel = 3'd0;
    ifb.en     = 1'b0;
    ifb.clear  = 1'b0;
    ifb.rd_sel = 3'd0;
    set_sig(1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // Reset state
    for (int i = 0; i < 8; i++) rd(0, 0, 3'(i), 8'h00, $sformatf("reset_sel%0d", i));
    rd(0, 1, 3'd0, 8'h00, "reset_valid");
    rd(0, 2, 3'd0, 8'h00, "reset_ovf");
    rd(1, 0, 3'd7, 8'h00, "reset9_status");

    // 80 high / 80 low
    ifa.en = 1'b1;
    level(1'b1, 80);
    level(1'b0, 80);
    set_sig(1'b1);
    tick(LAT);
    rd(0, 0, 3'd0, 8'h50, "t1_high_lo");
    rd(0, 0, 3'd1, 8'h00, "t1_high_hi");
    rd(0, 0, 3'd2, 8'h50, "t1_low_lo");
    rd(0, 0, 3'd3, 8'h00, "t1_low_hi");
    rd(0, 0, 3'd4, 8'hA0, "t1_period_lo");
    rd(0, 0, 3'd5, 8'h00, "t1_period_hi");
    rd(0, 0, 3'd6, 8'h01, "t1_pulse_cnt");
    rd(0, 1, 3'd0, 8'h01, "t1_valid");
    rd(0, 0, 3'd7, 8'h9C, "t1_status");

    // 20 high / 300 low, five periods
    ifa.clear = 1'b1;
    tick(1);
    ifa.clear = 1'b0;
    level(1'b0, 300);
    for (int p = 0; p < 5; p++) begin
      level(1'b1, 20);
      level(1'b0, 300);
    end
    set_sig(1'b1);
    tick(LAT);
    rd(0, 0, 3'd0, 8'h14, "t2_high_lo");
    rd(0, 0, 3'd2, 8'h2C, "t2_low_lo");
    rd(0, 0, 3'd3, 8'h01, "t2_low_hi");
    rd(0, 0, 3'd4, 8'h40, "t2_period_lo");
    rd(0, 0, 3'd5, 8'h01, "t2_period_hi");
    rd(0, 0, 3'd6, 8'h05, "t2_pulse_cnt");
    rd(0, 2, 3'd0, 8'h00, "t2_ovf");
    rd(0, 1, 3'd0, 8'h01, "t2_valid");

    // en low for five cycles mid-measurement, then resume
    ifa.en = 1'b0;
    rd(0, 0, 3'd6, 8'h05, "t4_hold_pulse_cnt");
    rd(0, 0, 3'd0, 8'h14, "t4_hold_high");
    rd(0, 0, 3'd2, 8'h2C, "t4_hold_low");
    rd(0, 0, 3'd4, 8'h40, "t4_hold_period");
    rd(0, 0, 3'd7, 8'h88, "t4_idle_status");
    ifa.en = 1'b1;
    tick(10);
    level(1'b0, 40);
    set_sig(1'b1);
    tick(LAT);
    rd(0, 0, 3'd2, 8'h28, "t4_first_low");
    rd(0, 0, 3'd6, 8'h05, "t4_no_period_yet");
    rd(0, 0, 3'd0, 8'h14, "t4_partial_high_dropped");
    tick(30 - LAT - 3);
    level(1'b0, 60);
    set_sig(1'b1);
    tick(LAT);
    rd(0, 0, 3'd0, 8'h1E, "t4_high");
    rd(0, 0, 3'd2, 8'h3C, "t4_low");
    rd(0, 0, 3'd4, 8'h5A, "t4_period");
    rd(0, 0, 3'd6, 8'h06, "t4_pulse_cnt");

    // clear in the same cycle as a detected rise
    level(1'b0, 50);
    set_sig(1'b1);
    tick(LAT - 1);
    ifa.clear = 1'b1;
    tick(1);
    ifa.clear = 1'b0;
    for (int i = 0; i < 7; i++) rd(0, 0, 3'(i), 8'h00, $sformatf("t5_clr_sel%0d", i));
    rd(0, 0, 3'd7, 8'h08, "t5_status_wait");
    rd(0, 1, 3'd0, 8'h00, "t5_valid");

    // CNT_W=9 saturation and sticky ovf
    ifb.en = 1'b1;
    tick(2);
    level(1'b0, 10);
    level(1'b1, 600);
    level(1'b0, 10);
    set_sig(1'b1);
    tick(LAT);
    rd(1, 0, 3'd0, 8'hFF, "t3_high_lo");
    rd(1, 0, 3'd1, 8'h01, "t3_high_hi");
    rd(1, 0, 3'd2, 8'h0A, "t3_low_lo");
    rd(1, 0, 3'd4, 8'hFF, "t3_period_lo");
    rd(1, 0, 3'd5, 8'h01, "t3_period_hi");
    rd(1, 0, 3'd6, 8'h01, "t3_pulse_cnt");
    rd(1, 2, 3'd0, 8'h01, "t3_ovf");
    tick(20 - LAT - 7);
    level(1'b0, 20);
    set_sig(1'b1);
    tick(LAT);
    rd(1, 0, 3'd0, 8'h14, "t3_clean_high");
    rd(1, 0, 3'd2, 8'h14, "t3_clean_low");
    rd(1, 0, 3'd4, 8'h28, "t3_clean_period");
    rd(1, 0, 3'd6, 8'h02, "t3_clean_pulse_cnt");
    rd(1, 2, 3'd0, 8'h01, "t3_ovf_sticky");
    ifb.clear = 1'b1;
    tick(1);
    ifb.clear = 1'b0;
    rd(1, 2, 3'd0, 8'h00, "t3_ovf_cleared");
    rd(1, 0, 3'd6, 8'h00, "t3_pulse_cnt_cleared");
    rd(1, 1, 3'd0, 8'h00, "t3_valid_cleared");

    // Asynchronous reset while in MEAS_LOW
    level(1'b0, 10);
    level(1'b1, 10);
    level(1'b0, 10);
    rd(0, 0, 3'd0, 8'h0A, "t6_pre_high");
    rst_n = 1'b0;
    rd(0, 0, 3'd0, 8'h00, "t6_async_high");
    rd(0, 0, 3'd7, 8'h00, "t6_async_status");
    rd(0, 1, 3'd0, 8'h00, "t6_async_valid");
    rst_n = 1'b1;
    tick(1);

`ifdef PM_GLITCH_FILTER_EN
    // One-cycle glitch inside a 100-cycle low is absorbed
    level(1'b1, 10);
    level(1'b0, 50);
    level(1'b1, 1);
    level(1'b0, 49);
    set_sig(1'b1);
    tick(LAT);
    rd(0, 0, 3'd2, 8'h64, "t6_glitch_low");
    rd(0, 0, 3'd0, 8'h0A, "t6_glitch_high");
`endif

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/ne555_pulse_meter.md
Name: ne555_pulse_meter

Overview:
Downstream measurement stage for the NE555EX timer core. It samples the timer's OUT signal and measures the last complete high time, low time and period in clk cycles. It also counts completed periods and exposes all results through an 8-bit byte-select readout. The tapeout top uses it to expose and self-check timer waveforms without an external logic analyser.

Parameters:
CNT_W, 16, width of length counters; legal range 9..16; readout bytes zero-extended to 16 bits.
SYNC_STAGES, 2, depth of the input synchroniser on sig_in; legal range 2..3.

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
en  input  1  measurement enable; low = idle, results held
clear  input  1  synchronous clear of all results and flags
sig_in  input  1  waveform under test (timer OUT, may be asynchronous)
rd_sel  input  3  readout byte select
rd_data  output  8  selected result byte
valid  output  1  at least one full high+low period captured since reset/clear
ovf  output  1  sticky: a level exceeded 2^CNT_W-1 cycles

Behaviour:
- Reset values:
  - sync chain, s_d, run_cnt, high_len, low_len, period, pulse_cnt: 0.
  - got_high, valid, ovf: 0.
  - state: WAIT_EDGE.
  - rd_data reflects these zeroed registers.
- Input path:
  - sig_in passes through SYNC_STAGES flops; s is the last stage; s_d is s delayed one cycle.
  - rise = s & ~s_d; fall = ~s & s_d.
- States: WAIT_EDGE (0), MEAS_HIGH (1), MEAS_LOW (2). Encoding 3 is unreachable and returns to WAIT_EDGE.
- WAIT_EDGE:
  - run_cnt holds 0; the first partial level after reset, clear or enable is discarded.
  - rise -> MEAS_HIGH, run_cnt <= 1.
  - fall -> MEAS_LOW, run_cnt <= 1.
- MEAS_HIGH:
  - No edge: run_cnt <= run_cnt+1, saturating at 2^CNT_W-1. An increment attempt at saturation sets ovf.
  - fall: high_len <= run_cnt; got_high <= 1; run_cnt <= 1; -> MEAS_LOW.
- MEAS_LOW:
  - No edge: counts and saturates identically to MEAS_HIGH.
  - rise: low_len <= run_cnt; run_cnt <= 1; -> MEAS_HIGH.
  - On the same rise, if got_high: period <= high_len + run_cnt (saturating, sets ovf on saturation), pulse_cnt <= pulse_cnt+1 (8-bit, wraps 255->0), valid <= 1.
- Exactness: a clean level of N synchronised cycles captures exactly N. Capture registers update on the clock edge ending the cycle in which the edge is detected.
- Latency: a sig_in transition reaches the capture registers SYNC_STAGES+1 clocks later.
- en low:
  - Next clock: state <= WAIT_EDGE, run_cnt <= 0, got_high <= 0.
  - high_len, low_len, period, pulse_cnt, valid and ovf are held; the sync chain keeps running.
- clear (synchronous):
  - Zeroes every register except the sync chain and s_d; state <= WAIT_EDGE.
  - Priority: clear > en low > edge handling in the same cycle.
- rd_data is combinational from registers, never from run_cnt:
  - 0 = high_len[7:0], 1 = high_len[15:8]
  - 2 = low_len[7:0], 3 = low_len[15:8]
  - 4 = period[7:0], 5 = period[15:8]
  - 6 = pulse_cnt
  - 7 = {valid, ovf, state[1:0], s, got_high, 2'b00}
- Result updates are single-cycle. Multi-byte reads that straddle an update are not guaranteed coherent; software reads pulse_cnt before and after to detect this.

Optional Feature:
Macro PM_GLITCH_FILTER_EN.
- Defined: a 2-bit stability counter sits between s and the edge logic. The filtered level f changes only after s has held its new value for 3 consecutive cycles. rise/fall/s_d use f instead of s, and latency grows by 2 clocks. Measured lengths are unchanged for clean levels of 3 or more cycles; shorter pulses are ignored and count into the surrounding level. Status bit 3 reports f.
- Undefined: no filter; behaviour exactly as above.

Test Plan:
1. Reset, then sig_in high 80 / low 80 cycles repeating with en=1 -> after 2nd rise: high_len=80, low_len=80, period=160, pulse_cnt=1, valid=1; rd_sel=4 gives 0xA0, rd_sel=5 gives 0x00.
2. sig_in high 20 / low 300 for 5 periods -> rd_sel=2/3 = 0x2C/0x01, period=320, pulse_cnt=5, ovf=0.
3. CNT_W=9, sig_in held high 600 cycles then low 10 then high -> high_len=511, ovf=1 and stays 1 after further clean periods until clear.
4. Mid-measurement, drop en for 5 cycles, then resume -> results unchanged while low; first partial level after re-enable discarded; pulse_cnt increments only after a full new high+low.
5. Assert clear and a rise in the same cycle -> all results 0, valid=0, state=WAIT_EDGE; the edge is ignored.
6. Assert rst_n low asynchronously during MEAS_LOW -> outputs zero immediately without a clock. With PM_GLITCH_FILTER_EN, a 1-cycle high glitch inside a 100-cycle low is ignored, so low_len=100.
